// File: rtl/jt49_div_bank.sv
// Multi-channel programmable tone divider: each channel divides the cen stream
// by its period, producing a square wave (div) and a one-cycle terminal strobe (tick).
module jt49_div_bank #(
    parameter int CH     = 3,
    parameter int W      = 12,
    parameter int SHADOW = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cen,
    input  logic [CH*W-1:0] period,
    input  logic [CH-1:0]   en,
    input  logic [CH-1:0]   restart,
    output logic [CH-1:0]   div,
    output logic [CH-1:0]   tick
);

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [W-1:0] count;
        logic [W-1:0] shadow;
        logic [W-1:0] per;
        logic [W-1:0] p_eff;
        logic         div_r;
        logic         tick_r;

        assign per   = period[c*W +: W];
        assign p_eff = (SHADOW != 0) ? shadow : per;
        assign div[c]  = div_r;
        assign tick[c] = tick_r;

        // Terminal test is >= so a period shrinking below the running count
        // terminates immediately rather than wrapping through 2^W.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count  <= W'(1);
                div_r  <= 1'b0;
                tick_r <= 1'b0;
                shadow <= '0;
            end else if (restart[c]) begin
                count  <= W'(1);
                div_r  <= 1'b0;
                tick_r <= 1'b0;
                shadow <= per;
            end else if (!cen || !en[c]) begin
                tick_r <= 1'b0;
            end else if (p_eff == '0) begin
                tick_r <= 1'b0;
                shadow <= per;
            end else if (count >= p_eff) begin
                count  <= W'(1);
                div_r  <= ~div_r;
                tick_r <= 1'b1;
                if (SHADOW != 0) shadow <= per;
            end else begin
                count  <= count + W'(1);
                tick_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jt49_div_bank.sv
// Directed bench for jt49_div_bank: expected tick events are queued by the
// stimulus and matched by a monitor whenever any channel strobes tick.
module tb_jt49_div_bank;

    typedef struct {
        int   id;
        int   cyc;
        logic dv;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_n_c = 1'b0;
    logic        cen_a = 1'b0, cen_b = 1'b0, cen_c = 1'b0;
    logic [35:0] period_a = '0, period_b = '0;
    logic [11:0] period_c = '0;
    logic [2:0]  en_a = '0, en_b = '0, en_c = '0;
    logic [2:0]  restart_a = '0, restart_b = '0, restart_c = '0;
    logic [2:0]  div_a, div_b, div_c, tick_a, tick_b, tick_c;

    logic [2:0]  tk [3];
    logic [2:0]  dv [3];
    ev_t         exp_q [$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          base;
    int          r;

    jt49_div_bank #(.CH(3), .W(12), .SHADOW(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .cen(cen_a), .period(period_a),
        .en(en_a), .restart(restart_a), .div(div_a), .tick(tick_a));

    jt49_div_bank #(.CH(3), .W(12), .SHADOW(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .cen(cen_b), .period(period_b),
        .en(en_b), .restart(restart_b), .div(div_b), .tick(tick_b));

    jt49_div_bank #(.CH(3), .W(4), .SHADOW(1)) dut_c (
        .clk(clk), .rst_n(rst_n_c), .cen(cen_c), .period(period_c),
        .en(en_c), .restart(restart_c), .div(div_c), .tick(tick_c));

    assign tk[0] = tick_a;
    assign tk[1] = tick_b;
    assign tk[2] = tick_c;
    assign dv[0] = div_a;
    assign dv[1] = div_b;
    assign dv[2] = div_c;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic void push(int id, int cy, logic d);
        ev_t e;
        e.id  = id;
        e.cyc = cy;
        e.dv  = d;
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        ev_t e;
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < 3; c++) begin
                if (tk[d][c] === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL tick_extra dut=%0d ch=%0d cyc=%0d got=tick expected=none",
                                 d, c, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.id != d*8 + c || e.cyc != cyc || e.dv !== dv[d][c]) begin
                            failures++;
                            $display("FAIL tick_event got id=%0d cyc=%0d div=%b expected id=%0d cyc=%0d div=%b",
                                     d*8 + c, cyc, dv[d][c], e.id, e.cyc, e.dv);
                        end
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) step();
        chk("rst_div_a", 32'(div_a), 0);
        chk("rst_tick_a", 32'(tick_a), 0);
        chk("rst_div_b", 32'(div_b), 0);
        chk("rst_tick_b", 32'(tick_b), 0);
        chk("rst_div_c", 32'(div_c), 0);
        chk("rst_tick_c", 32'(tick_c), 0);
        rst_n = 1'b1;
        rst_n_c = 1'b1;

        // idle: zero periods never count
        en_a = 3'b111;
        cen_a = 1'b1;
        repeat (50) begin
            step();
            chk("idle_div", 32'(div_a), 0);
            chk("idle_tick", 32'(tick_a), 0);
        end
        cen_a = 1'b0;
        en_a = '0;

        // ch0 period 3, cen every second clk
        period_a[11:0] = 12'd3;
        en_a = 3'b001;
        restart_a = 3'b001;
        step();
        base = cyc;
        restart_a = '0;
        for (int m = 1; m <= 4; m++) push(0, base + 6*m - 1, logic'(m % 2));
        for (int j = 1; j <= 24; j++) begin
            cen_a = logic'(j % 2);
            step();
        end
        cen_a = 1'b0;
        en_a = '0;
        step();

        // ch1 period 1, cen continuous
        period_a[23:12] = 12'd1;
        en_a = 3'b010;
        restart_a = 3'b010;
        step();
        base = cyc;
        restart_a = '0;
        for (int j = 1; j <= 8; j++) push(1, base + j, logic'(j % 2));
        cen_a = 1'b1;
        repeat (8) step();
        cen_a = 1'b0;
        en_a = '0;
        step();

        // shadowed period change 10 -> 2 at count 4
        period_a[11:0] = 12'd10;
        en_a = 3'b001;
        restart_a = 3'b001;
        step();
        base = cyc;
        restart_a = '0;
        cen_a = 1'b1;
        push(0, base + 10, 1'b1);
        push(0, base + 12, 1'b0);
        push(0, base + 14, 1'b1);
        repeat (3) step();
        period_a[11:0] = 12'd2;
        repeat (12) step();
        cen_a = 1'b0;
        en_a = '0;
        step();

        // live period change 10 -> 2 at count 4
        period_b[11:0] = 12'd10;
        en_b = 3'b001;
        restart_b = 3'b001;
        step();
        base = cyc;
        restart_b = '0;
        cen_b = 1'b1;
        push(8, base + 4, 1'b1);
        push(8, base + 6, 1'b0);
        push(8, base + 8, 1'b1);
        repeat (3) step();
        period_b[11:0] = 12'd2;
        repeat (6) step();
        cen_b = 1'b0;
        en_b = '0;
        step();

        // restart on the terminal edge of ch2
        period_a[35:24] = 12'd5;
        en_a = 3'b100;
        restart_a = 3'b100;
        step();
        base = cyc;
        restart_a = '0;
        cen_a = 1'b1;
        push(2, base + 10, 1'b1);
        repeat (4) step();
        restart_a = 3'b100;
        step();
        restart_a = '0;
        chk("restart_div", 32'(div_a[2]), 0);
        chk("restart_tick", 32'(tick_a[2]), 0);
        repeat (6) step();
        cen_a = 1'b0;
        en_a = '0;
        step();

        // enable freeze, then zero period on the shadowed divider
        period_a[23:12] = 12'd4;
        en_a = 3'b010;
        restart_a = 3'b010;
        step();
        base = cyc;
        restart_a = '0;
        cen_a = 1'b1;
        step();
        en_a = '0;
        repeat (7) step();
        chk("freeze_div", 32'(div_a[1]), 0);
        en_a = 3'b010;
        push(1, base + 11, 1'b1);
        repeat (4) step();
        period_a[23:12] = 12'd0;
        push(1, base + 15, 1'b0);
        repeat (8) step();
        period_a[23:12] = 12'd4;
        push(1, base + 25, 1'b1);
        repeat (6) step();
        cen_a = 1'b0;
        en_a = '0;
        step();

        // zero period on the live divider
        period_b[23:12] = 12'd4;
        en_b = 3'b010;
        restart_b = 3'b010;
        step();
        base = cyc;
        restart_b = '0;
        cen_b = 1'b1;
        repeat (2) step();
        period_b[23:12] = 12'd0;
        repeat (6) step();
        period_b[23:12] = 12'd4;
        push(9, base + 10, 1'b1);
        repeat (3) step();
        cen_b = 1'b0;
        en_b = '0;
        step();

        // W=4 max period, then async reset mid-cycle
        period_c[3:0] = 4'd15;
        en_c = 3'b001;
        restart_c = 3'b001;
        step();
        base = cyc;
        restart_c = '0;
        cen_c = 1'b1;
        repeat (14) step();
        chk("max_div_before", 32'(div_c[0]), 0);
        step();
        chk("max_div_toggle", 32'(div_c[0]), 1);
        chk("max_tick", 32'(tick_c[0]), 1);
        #1 rst_n_c = 1'b0;
        #1;
        chk("async_div", 32'(div_c), 0);
        chk("async_tick", 32'(tick_c), 0);
        repeat (2) step();
        rst_n_c = 1'b1;
        r = cyc;
        push(16, r + 16, 1'b1);
        repeat (17) step();
        cen_c = 1'b0;
        en_c = '0;
        repeat (3) step();

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
